// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative multiply/divide sequencer
//
// Purpose: op codes, sequencer state enum and ALU control constants used by
// alu_muldiv_seq. A subtract is issued to the external ALU as ADD with
// b-invert and carry-in both set (a + ~b + 1).
package muldiv_pkg;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULHU = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_REMU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ITER = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [3:0] ALU_OP_ADD     = 4'b0010;
   localparam logic       ALU_SUB_INVERT = 1'b1;
   localparam logic       ALU_SUB_CARRY  = 1'b1;

   // Divide-family ops share op[1] = 1.
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   // MULHU and REMU return the hi register, MUL and DIVU the lo register.
   function automatic logic op_takes_hi(input logic [1:0] op);
      return (op == OP_MULHU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative unsigned mul/div sequencer driving an external ALU
//
// Purpose: shift-add multiply and restoring divide, one ALU operation per
// cycle, N iterations per operation. The ALU itself lives in the parent.
// Optional build macro: MULDIV_ZERO_SKIP_EN (MUL/MULHU with a zero operand
// finish one cycle after accept with result 0).
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   start_i, op_i            request and op code (sampled only in IDLE)
//   rs1_i, rs2_i             multiplicand/dividend, multiplier/divisor
//   busy_o                   high from accept through the last ITER cycle
//   done_o                   one-cycle pulse, result_o valid
//   result_o, div_by_zero_o  result and divide-by-zero flag, held to next done
//   alu_a_o, alu_b_o         ALU operands
//   alu_c_o, alu_invert_o    ALU carry-in and b-invert
//   alu_op_o                 ALU operation code
//   alu_res_i, alu_c_i       ALU result and carry-out (same cycle)
module alu_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [1:0]   op_i,
   input  logic [N-1:0] rs1_i,
   input  logic [N-1:0] rs2_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] result_o,
   output logic         div_by_zero_o,
   output logic [N-1:0] alu_a_o,
   output logic [N-1:0] alu_b_o,
   output logic         alu_c_o,
   output logic         alu_invert_o,
   output logic [3:0]   alu_op_o,
   input  logic [N-1:0] alu_res_i,
   input  logic         alu_c_i
);

   localparam int CW = $clog2(N);

   state_t        state_q;
   logic [1:0]    op_q;
   logic [N-1:0]  hi_q;
   logic [N-1:0]  lo_q;
   logic [N-1:0]  opnd_q;    // multiplicand (MUL) or divisor (DIV)
   logic [CW-1:0] cnt_q;
   logic [3:0]    alu_op_q;

   logic [N-1:0]  hi_nxt;
   logic [N-1:0]  lo_nxt;
   logic [N-1:0]  rem_r;
   logic          qbit;
   logic          start_div;
   logic          last_iter;

   assign start_div = op_is_div(op_i);
   assign last_iter = (cnt_q == CW'(N - 1));
   assign alu_op_o  = alu_op_q;

   // ALU drive and next hi/lo. The ALU result feeds straight back into the
   // registers, so operands must be combinational from the current hi/lo.
   always_comb begin
      alu_a_o      = '0;
      alu_b_o      = '0;
      alu_c_o      = 1'b0;
      alu_invert_o = 1'b0;
      rem_r        = {hi_q[N-2:0], lo_q[N-1]};
      qbit         = 1'b0;
      hi_nxt       = hi_q;
      lo_nxt       = lo_q;
      if (state_q == S_ITER) begin
         alu_b_o = opnd_q;
         if (op_is_div(op_q)) begin
            alu_a_o      = rem_r;
            alu_invert_o = ALU_SUB_INVERT;
            alu_c_o      = ALU_SUB_CARRY;
            // hi[N-1] set means the shifted remainder is >= 2^N, which always
            // exceeds the divisor even though the N-bit subtract borrows.
            qbit   = alu_c_i | hi_q[N-1];
            hi_nxt = qbit ? alu_res_i : rem_r;
            lo_nxt = {lo_q[N-2:0], qbit};
         end else begin
            alu_a_o = hi_q;
            if (lo_q[0]) begin
               hi_nxt = {alu_c_i, alu_res_i[N-1:1]};
               lo_nxt = {alu_res_i[0], lo_q[N-1:1]};
            end else begin
               hi_nxt = {1'b0, hi_q[N-1:1]};
               lo_nxt = {hi_q[0], lo_q[N-1:1]};
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         op_q          <= OP_MUL;
         hi_q          <= '0;
         lo_q          <= '0;
         opnd_q        <= '0;
         cnt_q         <= '0;
         alu_op_q      <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         div_by_zero_o <= 1'b0;
         result_o      <= '0;
      end else begin
         alu_op_q <= ALU_OP_ADD;
         case (state_q)
            S_IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  op_q   <= op_i;
                  hi_q   <= '0;
                  lo_q   <= start_div ? rs1_i : rs2_i;
                  opnd_q <= start_div ? rs2_i : rs1_i;
                  cnt_q  <= '0;
                  if (start_div && (rs2_i == '0)) begin
                     result_o      <= (op_i == OP_DIVU) ? '1 : rs1_i;
                     div_by_zero_o <= 1'b1;
                     done_o        <= 1'b1;
                     state_q       <= S_DONE;
                  end
`ifdef MULDIV_ZERO_SKIP_EN
                  else if (!start_div && ((rs1_i == '0) || (rs2_i == '0))) begin
                     result_o      <= '0;
                     div_by_zero_o <= 1'b0;
                     done_o        <= 1'b1;
                     state_q       <= S_DONE;
                  end
`endif
                  else begin
                     busy_o  <= 1'b1;
                     state_q <= S_ITER;
                  end
               end
            end
            S_ITER: begin
               hi_q  <= hi_nxt;
               lo_q  <= lo_nxt;
               cnt_q <= cnt_q + CW'(1);
               if (last_iter) begin
                  cnt_q         <= '0;
                  busy_o        <= 1'b0;
                  done_o        <= 1'b1;
                  div_by_zero_o <= 1'b0;
                  result_o      <= op_takes_hi(op_q) ? hi_nxt : lo_nxt;
                  state_q       <= S_DONE;
               end
            end
            S_DONE: begin
               done_o  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq with an N-bit adder ALU
module tb_alu_muldiv_seq;

   localparam int N = 32;
   localparam logic [3:0] ADD_CODE = 4'b0010;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         start_i;
   logic [1:0]   op_i;
   logic [N-1:0] rs1_i;
   logic [N-1:0] rs2_i;
   logic         busy_o;
   logic         done_o;
   logic [N-1:0] result_o;
   logic         div_by_zero_o;
   logic [N-1:0] alu_a_o;
   logic [N-1:0] alu_b_o;
   logic         alu_c_o;
   logic         alu_invert_o;
   logic [3:0]   alu_op_o;
   logic [N-1:0] alu_res_i;
   logic         alu_c_i;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   alu_muldiv_seq #(.N(N)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .op_i         (op_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .result_o     (result_o),
      .div_by_zero_o(div_by_zero_o),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_c_o      (alu_c_o),
      .alu_invert_o (alu_invert_o),
      .alu_op_o     (alu_op_o),
      .alu_res_i    (alu_res_i),
      .alu_c_i      (alu_c_i)
   );

   // External ALU: add with optional b-invert and carry-in.
   logic [N:0] alu_sum;
   always_comb begin
      alu_sum = '0;
      if (alu_op_o == ADD_CODE)
         alu_sum = {1'b0, alu_a_o} + {1'b0, (alu_invert_o ? ~alu_b_o : alu_b_o)} + {{N{1'b0}}, alu_c_o};
      alu_res_i = alu_sum[N-1:0];
      alu_c_i   = alu_sum[N];
   end

   // Reference: plain arithmetic on the architectural definition of each op.
   function automatic logic [N-1:0] model_result(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] p;
      p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      case (op)
         2'b00:   return p[N-1:0];
         2'b01:   return p[2*N-1:N];
         2'b10:   return (b == 0) ? {N{1'b1}} : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_latency(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      if (op[1] && b == 0) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
      if (!op[1] && (a == 0 || b == 0)) return 1;
`endif
      return N + 1;
   endfunction

   // Issue one request and collect observations; latency counts cycles from
   // the cycle start_i is presented to the cycle done_o is seen.
   task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] res, output logic dz, output int lat, output int busy_cnt);
      @(negedge clk_i);
      start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
      @(negedge clk_i);
      start_i = 1'b0;
      lat = 1; busy_cnt = 0;
      while (!done_o && lat < 200) begin
         if (busy_o) busy_cnt++;
         @(negedge clk_i);
         lat++;
      end
      checks++;
      if (!done_o) begin
         errors++;
         $display("FAIL done_timeout op=%0d got no done_o within %0d cycles", op, lat);
      end
      res = result_o;
      dz  = div_by_zero_o;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; start_i = 1'b0; op_i = 2'b00; rs1_i = '0; rs2_i = '0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({busy_o, done_o, div_by_zero_o} !== 3'b000 || result_o !== '0) begin
         errors++;
         $display("FAIL reset_outputs busy/done/dbz=%b%b%b result=%h required 000 and 0", busy_o, done_o, div_by_zero_o, result_o);
      end
      checks++;
      if (alu_a_o !== '0 || alu_b_o !== '0 || alu_c_o !== 1'b0 || alu_invert_o !== 1'b0 || alu_op_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_alu a=%h b=%h c=%b inv=%b op=%h required all zero", alu_a_o, alu_b_o, alu_c_o, alu_invert_o, alu_op_o);
      end
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_mul_basic();
      logic [N-1:0] res; logic dz; int lat, bc;
      run_op(2'b00, 32'd7, 32'd6, res, dz, lat, bc);
      checks++;
      if (res !== 32'd42) begin errors++; $display("FAIL mul_7x6 got %0d required 42", res); end
      checks++;
      if (lat != 33) begin errors++; $display("FAIL mul_latency got %0d required 33", lat); end
      checks++;
      if (bc != 32) begin errors++; $display("FAIL mul_busy_cycles got %0d required 32", bc); end
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width done_o=%b required 0", done_o); end
      checks++;
      if (alu_a_o !== '0 || alu_b_o !== '0 || alu_c_o !== 1'b0 || alu_invert_o !== 1'b0 || alu_op_o !== ADD_CODE) begin
         errors++;
         $display("FAIL idle_alu a=%h b=%h c=%b inv=%b op=%h required 0,0,0,0,2", alu_a_o, alu_b_o, alu_c_o, alu_invert_o, alu_op_o);
      end
   endtask

   task automatic test_mul_wide();
      logic [N-1:0] res; logic dz; int lat, bc;
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, lat, bc);
      checks++;
      if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_max got %h required fffffffe", res); end
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, dz, lat, bc);
      checks++;
      if (res !== 32'h0000_0001) begin errors++; $display("FAIL mul_max got %h required 00000001", res); end
   endtask

   task automatic test_div();
      logic [N-1:0] res; logic dz; int lat, bc;
      run_op(2'b10, 32'd100, 32'd7, res, dz, lat, bc);
      checks++;
      if (res !== 32'd14 || dz !== 1'b0) begin errors++; $display("FAIL divu_100_7 got %0d dbz=%b required 14 dbz=0", res, dz); end
      run_op(2'b11, 32'd100, 32'd7, res, dz, lat, bc);
      checks++;
      if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %0d required 2", res); end
      run_op(2'b10, 32'hFFFF_FFFF, 32'd1, res, dz, lat, bc);
      checks++;
      if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max_1 got %h required ffffffff", res); end
      checks++;
      if (lat != 33) begin errors++; $display("FAIL divu_latency got %0d required 33", lat); end
   endtask

   task automatic test_div_by_zero();
      logic [N-1:0] res; logic dz; int lat, bc;
      run_op(2'b10, 32'd5, 32'd0, res, dz, lat, bc);
      checks++;
      if (res !== 32'hFFFF_FFFF || dz !== 1'b1) begin errors++; $display("FAIL divu_by_zero got %h dbz=%b required ffffffff dbz=1", res, dz); end
      checks++;
      if (lat != 1 || bc != 0) begin errors++; $display("FAIL divu_by_zero_latency got lat=%0d busy=%0d required 1 and 0", lat, bc); end
      @(negedge clk_i);
      checks++;
      if (div_by_zero_o !== 1'b1 || result_o !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL dbz_held dbz=%b result=%h required 1 and ffffffff", div_by_zero_o, result_o);
      end
      run_op(2'b11, 32'd5, 32'd0, res, dz, lat, bc);
      checks++;
      if (res !== 32'd5 || dz !== 1'b1 || lat != 1) begin errors++; $display("FAIL remu_by_zero got %0d dbz=%b lat=%0d required 5 1 1", res, dz, lat); end
   endtask

   task automatic test_reset_mid_op();
      logic [N-1:0] res; logic dz; int lat, bc; int cyc; int seen;
      @(negedge clk_i);
      start_i = 1'b1; op_i = 2'b00; rs1_i = 32'h1234; rs2_i = 32'h5678;
      @(negedge clk_i);
      start_i = 1'b0;
      cyc = 1;
      while (cyc < 10) begin @(negedge clk_i); cyc++; end
      rst_ni = 1'b0;
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0) begin
         errors++; $display("FAIL reset_mid_op busy=%b done=%b result=%h required 0 0 0", busy_o, done_o, result_o);
      end
      rst_ni = 1'b1;
      seen = 0;
      repeat (40) begin @(negedge clk_i); if (done_o) seen++; end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL reset_no_done saw %0d done pulses required 0", seen); end
      run_op(2'b00, 32'd3, 32'd3, res, dz, lat, bc);
      checks++;
      if (res !== 32'd9) begin errors++; $display("FAIL mul_after_reset got %0d required 9", res); end
   endtask

   task automatic test_start_while_busy();
      int cyc; int seen; logic [3:0] iter_op; logic iter_inv;
      iter_op = '0; iter_inv = 1'b1;
      @(negedge clk_i);
      start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd7; rs2_i = 32'd6;
      @(negedge clk_i);
      start_i = 1'b0;
      cyc = 1;
      while (!done_o && cyc < 200) begin
         if (cyc == 3) begin iter_op = alu_op_o; iter_inv = alu_invert_o; end
         if (cyc == 5) begin start_i = 1'b1; op_i = 2'b10; rs1_i = 32'd100; rs2_i = 32'd7; end
         if (cyc == 6) start_i = 1'b0;
         @(negedge clk_i);
         cyc++;
      end
      checks++;
      if (iter_op !== ADD_CODE || iter_inv !== 1'b0) begin errors++; $display("FAIL mul_iter_alu op=%h inv=%b required 2 and 0", iter_op, iter_inv); end
      checks++;
      if (!done_o || result_o !== 32'd42 || cyc != 33) begin
         errors++; $display("FAIL busy_start_ignored done=%b result=%0d lat=%0d required 1 42 33", done_o, result_o, cyc);
      end
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      seen = 0;
      repeat (45) begin @(negedge clk_i); if (done_o || busy_o) seen++; end
      checks++;
      if (seen != 0 || result_o !== 32'd42) begin
         errors++; $display("FAIL done_start_ignored activity=%0d result=%0d required 0 and 42", seen, result_o);
      end
   endtask

   task automatic test_zero_operand();
      logic [N-1:0] res; logic dz; int lat, bc;
      run_op(2'b00, 32'd0, 32'd5, res, dz, lat, bc);
      checks++;
      if (res !== '0 || dz !== 1'b0) begin errors++; $display("FAIL mul_zero got %h dbz=%b required 0 0", res, dz); end
      checks++;
      if (lat != model_latency(2'b00, 32'd0, 32'd5)) begin
         errors++; $display("FAIL mul_zero_latency got %0d required %0d", lat, model_latency(2'b00, 32'd0, 32'd5));
      end
   endtask

   task automatic test_random();
      logic [N-1:0] res, a, b; logic dz; int lat, bc; logic [1:0] op;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0:       a = '0;
            1:       a = N'($urandom_range(1, 20));
            default: a = N'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = N'($urandom_range(1, 20));
            default: b = N'($urandom);
         endcase
         run_op(op, a, b, res, dz, lat, bc);
         checks++;
         if (res !== model_result(op, a, b) || dz !== (op[1] && b == 0) || lat != model_latency(op, a, b)) begin
            errors++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h got %h dbz=%b lat=%0d required %h dbz=%b lat=%0d",
                     i, op, a, b, res, dz, lat, model_result(op, a, b), (op[1] && b == 0), model_latency(op, a, b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_mul_wide();
      test_div();
      test_div_by_zero();
      test_reset_mid_op();
      test_start_while_busy();
      test_zero_operand();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
